led_blink_ctrl: RTL

IO-mapped controller that sequences the board LED from a 32-bit on/off pattern, clocked out one bit per programmable period, with one-shot or looping playback and a manual override. Sits on the PicoSoC iomem bus beside the other IO peripherals. It decodes its own address window and returns read data and ready. Firmware blinks status codes without cycle-counting in software.

---
 rtl/led_blink_pkg.sv | 30 +++
 rtl/led_blink_if.sv | 14 +
 rtl/led_blink_timebase.sv | 22 ++
 rtl/led_blink_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the LED blink controller.
package led_blink_pkg;

  localparam int PERIOD_W_DEF = 24;
  localparam int LEN_W        = 5;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_PERIOD  = 5'h04;
  localparam logic [4:0] OFF_PATTERN = 5'h08;
  localparam logic [4:0] OFF_BRIGHT  = 5'h0C;

  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_LOOP    = 2;
  localparam int CTRL_DONE    = 3;
  localparam int CTRL_MANUAL  = 4;
  localparam int CTRL_LEN_LSB = 8;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // Apply byte strobes: strobed bytes take wdata, others keep the old value.
  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [3:0] wstrb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/led_blink_if.sv
// PicoSoC iomem bus bundle: master drives requests, slave returns ready/rdata.
interface led_blink_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  input  iomem_ready, iomem_rdata);
  modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  output iomem_ready, iomem_rdata);
endinterface

// File: rtl/led_blink_timebase.sv
// Loadable down-counter: ticks for one cycle at zero and reloads itself.
module led_blink_timebase #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] reload_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q;

  // A load on the same cycle as a zero count restarts instead of ticking.
  assign tick_o = en_i && !load_i && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!resetn)               cnt_q <= '0;
    else if (load_i || tick_o) cnt_q <= reload_i;
    else if (en_i)             cnt_q <= cnt_q - W'(1);
  end
endmodule

// File: rtl/led_blink_ctrl.sv
// IO-mapped LED pattern sequencer on the PicoSoC iomem bus.
// Define LED_BLINK_PWM_EN to add the BRIGHT register and PWM gating of the LED.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0300_0000,
  parameter int          PERIOD_W  = PERIOD_W_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  led_blink_if.slave  bus,
  output logic        led,
  output logic        busy
);
  state_e               state_q, state_d;
  logic                 ready_q;
  logic [31:0]          rdata_q, rd_mux, ctrl_img, ctrl_wm, per_wm, pat_wm;
  logic                 loop_q, manual_q, done_q, done_d;
  logic [LEN_W-1:0]     len_q, sh_len_q, idx_q, idx_d;
  logic [PERIOD_W-1:0]  period_q, sh_per_q, per_m1;
  logic [31:0]          pattern_q, sh_pat_q;
  logic [2:0]           widx;
  logic                 sel_ctrl, sel_per, sel_pat, sel_bri;
  logic                 hit, acc, wr, rd, ctrl_start, ctrl_stop, sh_load, tick, led_log;
  logic                 unused_ok;

  assign widx     = bus.iomem_addr[4:2];
  assign sel_ctrl = (widx == OFF_CTRL[4:2]);
  assign sel_per  = (widx == OFF_PERIOD[4:2]);
  assign sel_pat  = (widx == OFF_PATTERN[4:2]);
`ifdef LED_BLINK_PWM_EN
  assign sel_bri  = (widx == OFF_BRIGHT[4:2]);
`else
  assign sel_bri  = 1'b0;
`endif

  // Only acknowledge when not already acking, so a held valid gets one ack.
  assign hit = bus.iomem_valid && (bus.iomem_addr[31:5] == ADDR_BASE[31:5])
            && (sel_ctrl || sel_per || sel_pat || sel_bri);
  assign acc = hit && !ready_q;
  assign wr  = acc && (bus.iomem_wstrb != 4'b0000);
  assign rd  = acc && (bus.iomem_wstrb == 4'b0000);

  assign ctrl_start = wr && sel_ctrl && bus.iomem_wstrb[0] && bus.iomem_wdata[CTRL_START];
  assign ctrl_stop  = wr && sel_ctrl && bus.iomem_wstrb[0] && bus.iomem_wdata[CTRL_STOP];

  assign busy   = (state_q == ST_RUN);
  assign per_m1 = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

  always_comb begin
    ctrl_img                             = '0;
    ctrl_img[CTRL_BUSY]                  = busy;
    ctrl_img[CTRL_LOOP]                  = loop_q;
    ctrl_img[CTRL_DONE]                  = done_q;
    ctrl_img[CTRL_MANUAL]                = manual_q;
    ctrl_img[CTRL_LEN_LSB +: LEN_W]      = len_q;
  end

  assign ctrl_wm = wmerge(ctrl_img, bus.iomem_wdata, bus.iomem_wstrb);
  assign per_wm  = wmerge(32'(period_q), bus.iomem_wdata, bus.iomem_wstrb);
  assign pat_wm  = wmerge(pattern_q, bus.iomem_wdata, bus.iomem_wstrb);
  assign unused_ok = ^{bus.iomem_addr[1:0], ctrl_wm, per_wm};

`ifdef LED_BLINK_PWM_EN
  logic [7:0]  bright_q, cnt_q;
  logic [31:0] bri_wm;
  logic        unused_pwm;

  assign bri_wm     = wmerge(32'(bright_q), bus.iomem_wdata, bus.iomem_wstrb);
  assign unused_pwm = ^bri_wm[31:8];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bright_q <= 8'hFF;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      if (wr && sel_bri) bright_q <= bri_wm[7:0];
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl)     rd_mux = ctrl_img;
    else if (sel_per) rd_mux = 32'(period_q);
    else if (sel_pat) rd_mux = pattern_q;
`ifdef LED_BLINK_PWM_EN
    else if (sel_bri) rd_mux = 32'(bright_q);
`endif
  end

  led_blink_timebase #(.W(PERIOD_W)) u_presc (
    .clk      (clk),
    .resetn   (resetn),
    .load_i   (sh_load),
    .en_i     (busy),
    .reload_i (sh_load ? per_m1 : sh_per_q),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = done_q;
    sh_load = 1'b0;
    if (rd && sel_ctrl) done_d = 1'b0;
    if (state_q == ST_RUN && tick) begin
      if (idx_q != sh_len_q) idx_d = idx_q + LEN_W'(1);
      else if (loop_q)       idx_d = '0;
      else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
    // STOP has priority over a START in the same write.
    if (ctrl_stop) begin
      state_d = ST_IDLE;
    end else if (ctrl_start) begin
      state_d = ST_RUN;
      idx_d   = '0;
      done_d  = 1'b0;
      sh_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      loop_q    <= 1'b0;
      manual_q  <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      period_q  <= '0;
      pattern_q <= '0;
      sh_len_q  <= '0;
      sh_per_q  <= '0;
      sh_pat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ready_q <= acc;
      rdata_q <= rd ? rd_mux : '0;
      if (wr && sel_ctrl) begin
        loop_q   <= ctrl_wm[CTRL_LOOP];
        manual_q <= ctrl_wm[CTRL_MANUAL];
        len_q    <= ctrl_wm[CTRL_LEN_LSB +: LEN_W];
      end
      if (wr && sel_per) period_q  <= per_wm[PERIOD_W-1:0];
      if (wr && sel_pat) pattern_q <= pat_wm;
      if (sh_load) begin
        sh_pat_q <= pattern_q;
        sh_per_q <= per_m1;
        sh_len_q <= ctrl_wm[CTRL_LEN_LSB +: LEN_W];
      end
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;

  assign led_log = busy ? sh_pat_q[idx_q] : manual_q;
`ifdef LED_BLINK_PWM_EN
  assign led = led_log & ((bright_q == 8'hFF) | (cnt_q < bright_q));
`else
  assign led = led_log;
`endif

endmodule
